// File: rtl/stable_pulse_tx_pkg.sv
// Definitions shared between the pulse transmitter and the glitch filter on the
// control input path.
package stable_pulse_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_t;

  // The receiver needs this many consecutive equal samples before it changes state.
  localparam int FILTER_DEPTH = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/stable_pulse_tx_if.sv
// Event strobe in, filtered-line pulse and status out.
interface stable_pulse_tx_if;
  logic evt;
  logic sig_out;
  logic busy;
  logic ovf;

  modport master (output evt, input sig_out, input busy, input ovf);
  modport slave  (input evt, output sig_out, output busy, output ovf);
endinterface

// File: rtl/stable_pulse_tx.sv
// Turns single-cycle event strobes into level pulses that are wide enough, and
// spaced far enough apart, to pass the downstream glitch filter one-for-one.
//
//   state | meaning
//   IDLE  | line low, nothing pending
//   HIGH  | line high for HIGH_CYCLES clocks
//   GAP   | line low for LOW_CYCLES clocks before the next pulse may start
module stable_pulse_tx
  import stable_pulse_tx_pkg::*;
#(
  parameter int HIGH_CYCLES = 4,
  parameter int LOW_CYCLES  = 4,
  parameter int MAX_PEND    = 3
) (
  input  logic              clock,
  input  logic              reset,
  stable_pulse_tx_if.slave  bus
);

  localparam int CW = $clog2(max_int(HIGH_CYCLES, LOW_CYCLES) + 1);
  localparam int PW = $clog2(MAX_PEND + 1);
  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] LOW_LOAD  = CW'(LOW_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX  = PW'(MAX_PEND);

  if (HIGH_CYCLES < FILTER_DEPTH) begin : g_bad_high
    $error("stable_pulse_tx: HIGH_CYCLES must be at least FILTER_DEPTH");
  end
  if (LOW_CYCLES < FILTER_DEPTH) begin : g_bad_low
    $error("stable_pulse_tx: LOW_CYCLES must be at least FILTER_DEPTH");
  end
  if (MAX_PEND < 1) begin : g_bad_pend
    $error("stable_pulse_tx: MAX_PEND must be at least 1");
  end

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [PW-1:0]  pend, pend_n;
  logic           ovf_q, ovf_n;
  logic           sig_q;
  logic           start;
  logic           take_pend;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= '0;
      ovf_q <= 1'b0;
      sig_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pend  <= pend_n;
      ovf_q <= ovf_n;
      sig_q <= (state_n == HIGH);
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    start     = 1'b0;
    take_pend = 1'b0;
    pend_n    = pend;
    ovf_n     = ovf_q;

    unique case (state)
      IDLE: begin
        if (bus.evt || (pend != '0)) begin
          start   = 1'b1;
          state_n = HIGH;
          cnt_n   = HIGH_LOAD;
        end
      end
      HIGH: begin
        if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = LOW_LOAD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (bus.evt || (pend != '0)) begin
            start   = 1'b1;
            state_n = HIGH;
            cnt_n   = HIGH_LOAD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // A start drains the queue first; a same-edge strobe then takes the freed slot.
    take_pend = start && (pend != '0);
    if (bus.evt && !(start && !take_pend)) begin
      if (!take_pend) begin
        if (pend < PEND_MAX) begin
          pend_n = pend + 1'b1;
        end else begin
          ovf_n = 1'b1;
        end
      end
    end else if (take_pend) begin
      pend_n = pend - 1'b1;
    end
  end

  assign bus.sig_out = sig_q;
  assign bus.busy    = (state != IDLE) || (pend != '0);
  assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_stable_pulse_tx.sv
// Directed bench for stable_pulse_tx at default parameters, with a small
// receive-filter model driven from sig_out for the loopback case.
module tb_stable_pulse_tx;
  import stable_pulse_tx_pkg::*;

  localparam int HIGH_CYCLES = 4;
  localparam int LOW_CYCLES  = 4;
  localparam int MAX_PEND    = 3;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  stable_pulse_tx_if bus ();

  stable_pulse_tx #(
    .HIGH_CYCLES (HIGH_CYCLES),
    .LOW_CYCLES  (LOW_CYCLES),
    .MAX_PEND    (MAX_PEND)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic evt;
    logic sig;
    logic busy;
    logic ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic e, input logic s, input logic b,
                              input logic o, input int n);
    vec_t v;
    v.evt  = e;
    v.sig  = s;
    v.busy = b;
    v.ovf  = o;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic e);
    bus.evt = e;
    @(posedge clock);
    #1;
  endtask

  task automatic run_bits(input string name, input logic [63:0] evt_b,
                          input logic [63:0] sig_b, input logic [63:0] busy_b,
                          input logic [63:0] ovf_b, input int n);
    for (int i = 0; i < n; i++) begin
      step(evt_b[i]);
      chk($sformatf("%s c%0d sig_out", name, i), 32'(bus.sig_out), 32'(sig_b[i]));
      chk($sformatf("%s c%0d busy", name, i), 32'(bus.busy), 32'(busy_b[i]));
      chk($sformatf("%s c%0d ovf", name, i), 32'(bus.ovf), 32'(ovf_b[i]));
    end
  endtask

  // Receiver model: output follows the line once three consecutive samples agree.
  logic       lb_en = 1'b0;
  logic [2:0] sh;
  logic       f_out;
  int         run_len;
  int         rises;

  always @(negedge clock) begin
    if (lb_en) begin
      sh = {sh[1:0], bus.sig_out};
      if (sh == 3'b111 && !f_out) begin
        f_out   = 1'b1;
        rises++;
        run_len = 0;
      end else if (sh == 3'b000 && f_out) begin
        f_out = 1'b0;
        chk("loopback high width", 32'(run_len), 32'(HIGH_CYCLES));
      end
      if (f_out) run_len++;
    end
  end

  logic [63:0] lb_evt;

  initial begin
    sh = '0; f_out = 1'b0; run_len = 0; rises = 0;

    // single event, then two back-to-back events
    add(1, 1, 1, 0, 1);
    add(0, 1, 1, 0, 3);
    add(0, 0, 1, 0, 4);
    add(0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 2);
    add(0, 1, 1, 0, 2);
    add(0, 0, 1, 0, 4);
    add(0, 1, 1, 0, 4);
    add(0, 0, 1, 0, 4);
    add(0, 0, 0, 0, 2);

    bus.evt = 1'b0;
    reset   = 1'b0;
    #12;
    chk("reset sig_out", 32'(bus.sig_out), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset ovf", 32'(bus.ovf), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].evt);
      chk($sformatf("vec%0d sig_out", i), 32'(bus.sig_out), 32'(vecs[i].sig));
      chk($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
    end

    // pend=1 plus a fresh strobe on the GAP->HIGH edge: queue stays at 1
    run_bits("gapend", 64'h0000_0000_0000_0103, 64'h0000_0000_000F_0F0F,
             64'h0000_0000_00FF_FFFF, 64'h0, 26);

    // five strobes in a row: three queued, fifth dropped
    run_bits("ovf", 64'h0000_0000_0000_001F, 64'h0000_0000_0F0F_0F0F,
             64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 34);

    // async reset mid-HIGH with pend=2 and ovf set
    step(1); step(1); step(1);
    chk("pre-reset ovf", 32'(bus.ovf), 32'd1);
    chk("pre-reset sig_out", 32'(bus.sig_out), 32'd1);
    bus.evt = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async reset sig_out", 32'(bus.sig_out), 32'd0);
    chk("async reset busy", 32'(bus.busy), 32'd0);
    chk("async reset ovf", 32'(bus.ovf), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(0);
      chk($sformatf("post-reset c%0d sig_out", i), 32'(bus.sig_out), 32'd0);
      chk($sformatf("post-reset c%0d busy", i), 32'(bus.busy), 32'd0);
    end

    // loopback through the filter model
    lb_evt = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 2) |
             (64'd1 << 20) | (64'd1 << 45) | (64'd1 << 46);
    lb_en = 1'b1;
    for (int c = 0; c < 80; c++) begin
      step((c < 64) ? lb_evt[c] : 1'b0);
    end
    lb_en = 1'b0;
    chk("loopback rising edges", 32'(rises), 32'd6);
    chk("loopback end busy", 32'(bus.busy), 32'd0);
    chk("loopback ovf", 32'(bus.ovf), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
